// File: rtl/uv_recon_sse.sv
// Chroma (8x8 U + 8x8 V) sum of squared error. The result is ready NBEATS+1 cycles after start. There is no backpressure: a start while busy is dropped.
// Optional per-plane results (sse_u/sse_v) are enabled by defining UV_SPLIT_SSE_EN.
module uv_recon_sse #(
  parameter int PIX_PER_CYCLE = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1023:0] UVsrc,
  input  logic [1023:0] UVout,
  output logic          busy,
  output logic [31:0]   sse,
  output logic          done
`ifdef UV_SPLIT_SSE_EN
  ,
  output logic [31:0]   sse_u,
  output logic [31:0]   sse_v
`endif
);

  localparam int P      = PIX_PER_CYCLE;
  localparam int NBEATS = 128 / P;
  localparam int CW     = $clog2(NBEATS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [23:0]     acc_q, sse_q, beat_sum;
  logic [1023:0]   src_q, out_q;
  logic [15:0]     sq [P];
  logic            last_beat, accept;

  assign last_beat = (cnt_q == CW'(NBEATS - 1));
  assign accept    = (state_q == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_beat) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The lowest P pixels of the shifting snapshot are the current beat.
  for (genvar j = 0; j < P; j++) begin : g_pix
    logic signed [8:0]  d;
    logic signed [15:0] dx;
    assign d     = $signed({1'b0, src_q[8*j +: 8]}) - $signed({1'b0, out_q[8*j +: 8]});
    assign dx    = 16'(d);
    assign sq[j] = dx * dx;
  end

  always_comb begin
    beat_sum = '0;
    for (int j = 0; j < P; j++) beat_sum = beat_sum + 24'(sq[j]);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      src_q <= UVsrc;
      out_q <= UVout;
    end else if (state_q == S_RUN) begin
      src_q <= src_q >> (8 * P);
      out_q <= out_q >> (8 * P);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      sse_q <= '0;
    end else if (accept) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      acc_q <= acc_q + beat_sum;
      cnt_q <= cnt_q + 1'b1;
      if (last_beat) sse_q <= acc_q + beat_sum;
    end
  end

  assign sse = {8'd0, sse_q};

`ifdef UV_SPLIT_SSE_EN
  logic [23:0] acc_u_q, acc_v_q, sse_u_q, sse_v_q, beat_u, beat_v;
  logic        pix_v [P];

  // Bit 3 of the original pixel index selects the V half of each 16-byte row.
  for (genvar j = 0; j < P; j++) begin : g_col
    logic [7:0] kidx;
    assign kidx     = 8'(cnt_q) * 8'(P) + 8'(j);
    assign pix_v[j] = kidx[3];
  end

  always_comb begin
    beat_u = '0;
    beat_v = '0;
    for (int j = 0; j < P; j++) begin
      if (pix_v[j]) beat_v = beat_v + 24'(sq[j]);
      else          beat_u = beat_u + 24'(sq[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_u_q <= '0;
      acc_v_q <= '0;
      sse_u_q <= '0;
      sse_v_q <= '0;
    end else if (accept) begin
      acc_u_q <= '0;
      acc_v_q <= '0;
    end else if (state_q == S_RUN) begin
      acc_u_q <= acc_u_q + beat_u;
      acc_v_q <= acc_v_q + beat_v;
      if (last_beat) begin
        sse_u_q <= acc_u_q + beat_u;
        sse_v_q <= acc_v_q + beat_v;
      end
    end
  end

  assign sse_u = {8'd0, sse_u_q};
  assign sse_v = {8'd0, sse_v_q};
`endif

endmodule
